// File: rtl/goal_detector_if.sv
// goal_detector_if: sensor/enable inputs and goal/status outputs of the goal detector
interface goal_detector_if;
  logic beam_raw;
  logic armed;
  logic goal;
  logic busy;
  logic sensor_fault;
  modport master (output beam_raw, armed, input goal, busy, sensor_fault);
  modport slave (input beam_raw, armed, output goal, busy, sensor_fault);
endinterface

// File: rtl/goal_detector.sv
// goal_detector: synchronised, debounced beam-break sensor to single-cycle goal pulse
// with post-goal lockout, cooldown and sticky stuck-sensor flag.
module goal_detector #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int COOLDOWN_CYC = 8,
  parameter int STUCK_CYC = 16
) (
  input logic clk,
  input logic rst,
  goal_detector_if.slave gd_if
);
  localparam int MAX_DC = DEBOUNCE_CYC > COOLDOWN_CYC ? DEBOUNCE_CYC : COOLDOWN_CYC;
  localparam int MAX_P = MAX_DC > STUCK_CYC ? MAX_DC : STUCK_CYC;
  localparam int W = $clog2(MAX_P + 1);
  localparam logic [W-1:0] D_END = W'(DEBOUNCE_CYC - 1);
  localparam logic [W-1:0] C_END = W'(COOLDOWN_CYC - 1);
  localparam logic [W-1:0] S_END = W'(STUCK_CYC - 1);
  localparam logic [W-1:0] S_MAX = W'(STUCK_CYC);
  typedef enum logic [2:0] {IDLE, QUAL, FIRE, HOLD, COOL} state_t;
  state_t state_q, state_d;
  logic s1_q, sync_q;
  logic [W-1:0] cnt_q, cnt_d, stuck_q, stuck_d;
  logic goal_q, busy_q, fault_q, fault_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    stuck_d = stuck_q;
    case (state_q)
      IDLE: if (gd_if.armed && sync_q) begin
        state_d = QUAL;
        cnt_d = W'(1);
      end
      QUAL: if (!sync_q || !gd_if.armed) begin
        state_d = IDLE;
        cnt_d = '0;
      end else if (cnt_q == D_END) state_d = FIRE;
      else cnt_d = cnt_q + 1'b1;
      FIRE: begin
        state_d = HOLD;
        stuck_d = '0;
      end
      HOLD: if (!sync_q) begin
        state_d = COOL;
        cnt_d = '0;
      end else if (stuck_q != S_MAX) stuck_d = stuck_q + 1'b1;
      COOL: if (cnt_q == C_END) begin
        state_d = IDLE;
        cnt_d = '0;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // fault latches on the last blocked HOLD sample before stuck_cnt saturates
  assign fault_d = fault_q | (state_q == HOLD && sync_q && stuck_q == S_END);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      sync_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      stuck_q <= '0;
      goal_q <= 1'b0;
      busy_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      s1_q <= gd_if.beam_raw;
      sync_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      stuck_q <= stuck_d;
      goal_q <= state_d == FIRE;
      busy_q <= state_d != IDLE;
      fault_q <= fault_d;
    end
  end
  assign gd_if.goal = goal_q;
  assign gd_if.busy = busy_q;
  assign gd_if.sensor_fault = fault_q;
endmodule

// File: tb/tb_goal_detector.sv
// tb_goal_detector: table vectors, directed corner sequences and random stimulus vs a timestamp model
module tb_goal_detector;
  localparam int D = 4;
  localparam int C = 8;
  localparam int S = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  goal_detector_if gi ();
  goal_detector #(.DEBOUNCE_CYC(D), .COOLDOWN_CYC(C), .STUCK_CYC(S)) dut (.clk(clk), .rst(rst), .gd_if(gi));
  always #5 clk = ~clk;
  int passed = 0;
  int total = 0;
  int ngoal = 0;
  int t = 0;
  int run = 0;
  bit locked = 0;
  int hold_edge = 0;
  int cool_end = -1;
  bit m_s1 = 0, m_sync = 0, m_goal = 0, m_busy = 0, m_fault = 0;
  typedef struct {int len; bit arm; int goals; bit fault;} vec_t;
  vec_t tbl[10];
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at t=%0d: got %0d, expected %0d", name, t, act, exp);
  endtask
  task automatic model_reset();
    run = 0; locked = 0; cool_end = -1;
    m_s1 = 0; m_sync = 0; m_goal = 0; m_busy = 0; m_fault = 0;
  endtask
  // goal fires on the D-th consecutive armed+blocked synced sample while unlocked;
  // the lock lasts until C edges after the first clear sample seen past HOLD entry
  task automatic model_edge(input bit r, input bit a);
    bit s;
    s = m_sync; m_sync = m_s1; m_s1 = r;
    m_goal = 0;
    if (!locked) begin
      run = (s && a) ? run + 1 : 0;
      if (run == D) begin
        m_goal = 1; locked = 1; hold_edge = t + 1; cool_end = -1; run = 0;
      end
      m_busy = locked || run > 0;
    end else begin
      if (cool_end < 0 && t > hold_edge) begin
        if (!s) cool_end = t + C;
        else if (t == hold_edge + S) m_fault = 1;
      end
      if (t == cool_end) locked = 0;
      m_busy = locked;
    end
    t++;
  endtask
  task automatic step(input bit r, input bit a);
    gi.beam_raw = r;
    gi.armed = a;
    @(posedge clk);
    model_edge(r, a);
    #1;
    chk("goal", gi.goal, m_goal);
    chk("busy", gi.busy, m_busy);
    chk("sensor_fault", gi.sensor_fault, m_fault);
    if (gi.goal) ngoal++;
  endtask
  task automatic do_reset();
    gi.beam_raw = 0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_goal", gi.goal, 0);
    chk("rst_busy", gi.busy, 0);
    chk("rst_fault", gi.sensor_fault, 0);
    rst = 0;
    ngoal = 0;
  endtask
  initial begin
    int gedge, bfirst, blast;
    tbl[0] = '{1, 1, 0, 0};
    tbl[1] = '{2, 1, 0, 0};
    tbl[2] = '{3, 1, 0, 0};
    tbl[3] = '{4, 1, 1, 0};
    tbl[4] = '{10, 1, 1, 0};
    tbl[5] = '{10, 0, 0, 0};
    tbl[6] = '{20, 1, 1, 0};
    tbl[7] = '{21, 1, 1, 1};
    tbl[8] = '{40, 1, 1, 1};
    tbl[9] = '{40, 0, 0, 0};
    gi.beam_raw = 0;
    gi.armed = 1;
    #1;
    do_reset();
    repeat (5) step(0, 1);
    for (int i = 0; i < 10; i++) begin
      do_reset();
      repeat (tbl[i].len) step(1, tbl[i].arm);
      repeat (30) step(0, tbl[i].arm);
      chk("tbl_goals", ngoal, tbl[i].goals);
      chk("tbl_fault", gi.sensor_fault, int'(tbl[i].fault));
      chk("tbl_busy_idle", gi.busy, 0);
    end
    do_reset();
    gedge = -1; bfirst = -1; blast = -1;
    for (int k = 0; k < 30; k++) begin
      step(k < 10, 1);
      if (gi.goal) gedge = k;
      if (gi.busy && bfirst < 0) bfirst = k;
      if (gi.busy) blast = k;
    end
    chk("clean_goal_edge", gedge, 5);
    chk("clean_busy_first", bfirst, 2);
    chk("clean_busy_last", blast, 19);
    chk("clean_goal_count", ngoal, 1);
    do_reset();
    for (int l = 1; l <= 3; l++) begin
      repeat (l) step(1, 1);
      repeat (10) step(0, 1);
      chk("glitch_busy", gi.busy, 0);
    end
    chk("glitch_goals", ngoal, 0);
    do_reset();
    repeat (3) step(1, 1);
    repeat (7) step(1, 0);
    repeat (20) step(0, 1);
    chk("disarm_goals", ngoal, 0);
    repeat (10) step(1, 1);
    repeat (3) step(0, 1);
    repeat (8) step(1, 1);
    repeat (20) step(0, 1);
    chk("cool_reblock_goals", ngoal, 1);
    repeat (10) step(1, 1);
    repeat (20) step(0, 1);
    chk("after_cool_goals", ngoal, 2);
    do_reset();
    for (int k = 0; k < 20 && !gi.goal; k++) step(1, 1);
    chk("midrst_goal_seen", gi.goal, 1);
    #3;
    rst = 1;
    #1;
    chk("midrst_goal", gi.goal, 0);
    chk("midrst_busy", gi.busy, 0);
    chk("midrst_fault", gi.sensor_fault, 0);
    do_reset();
    for (int seg = 0; seg < 300; seg++) begin
      bit r, a;
      int len;
      if ($urandom_range(0, 49) == 0) do_reset();
      r = $urandom_range(0, 1) == 1;
      a = $urandom_range(0, 9) != 0;
      len = r ? $urandom_range(1, 25) : $urandom_range(1, 14);
      repeat (len) step(r, a);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
